// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, classes, select codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CL_R,
        CL_IALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_LUI,
        CL_AUIPC
    } iclass_t;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Immediate extender format codes; must stay in step with the extender.
    localparam logic [2:0] IMM_I  = 3'b000;
    localparam logic [2:0] IMM_S  = 3'b001;
    localparam logic [2:0] IMM_SB = 3'b010;
    localparam logic [2:0] IMM_UJ = 3'b011;
    localparam logic [2:0] IMM_U  = 3'b100;

    // ALU operand A / B selects (B code 2 = constant 4 is reserved for the datapath).
    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;
    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_IMM  = 2'd1;

    // ALU operation
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_CMP   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // Next-PC source
    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_IMM   = 2'd1;
    localparam logic [1:0] PC_SRC_ALU   = 2'd2;

    // Register write-back source
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps instr[6:0] to an instruction class, immediate format and legality flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the FSM decides when the result is latched.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_t    cls,
    output logic [2:0] imm_sel,
    output logic       legal
);

    // Opcode lookup; anything not listed is illegal and sends the FSM to TRAP.
    always_comb begin
        cls     = CL_R;
        imm_sel = IMM_I;
        legal   = 1'b1;
        case (opcode)
            OPC_R:      begin cls = CL_R;      imm_sel = IMM_I;  end // no immediate, code 000
            OPC_IALU:   begin cls = CL_IALU;   imm_sel = IMM_I;  end
            OPC_LOAD:   begin cls = CL_LOAD;   imm_sel = IMM_I;  end
            OPC_STORE:  begin cls = CL_STORE;  imm_sel = IMM_S;  end
            OPC_BRANCH: begin cls = CL_BRANCH; imm_sel = IMM_SB; end
            OPC_JAL:    begin cls = CL_JAL;    imm_sel = IMM_UJ; end
            OPC_JALR:   begin cls = CL_JALR;   imm_sel = IMM_I;  end
            OPC_LUI:    begin cls = CL_LUI;    imm_sel = IMM_U;  end
            OPC_AUIPC:  begin cls = CL_AUIPC;  imm_sel = IMM_U;  end
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: START/FETCH/DECODE/EXEC/MEM/WB/TRAP with memory timeout watchdog.
// Latency: ALU ops 4 cycles after fetch ack path (FETCH..WB), branches retire in EXEC, loads add MEM.
// Backpressure: mem_req is held in FETCH/MEM until mem_ack; MEM_TIMEOUT unacked cycles trap with bus_err.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ack,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_src,
    output logic        ir_write,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        trap,
    output logic        bus_err
);

    localparam int              CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    iclass_t          cls_q, cls_d;
    logic [2:0]       imm_sel_q, imm_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             armed_q, armed_d;

    iclass_t          dec_cls;
    logic [2:0]       dec_imm;
    logic             dec_legal;
    logic             timeout;

    logic [1:0]       exec_a, exec_b, exec_op;

    // Only the opcode field steers control; the rest of instr feeds the datapath.
    logic             unused_instr_bits;
    assign unused_instr_bits = ^instr[31:7];

    ctrl_decode u_decode (
        .opcode  (instr[6:0]),
        .cls     (dec_cls),
        .imm_sel (dec_imm),
        .legal   (dec_legal)
    );

    assign timeout = (cnt_q == CNT_MAX);
    assign bus_err = bus_err_q;

    // ALU selects per latched class; reused in MEM and WB so the ALU result stays stable.
    always_comb begin
        exec_a  = ALU_A_RS1;
        exec_b  = ALU_B_RS2;
        exec_op = ALU_OP_ADD;
        case (cls_q)
            CL_R:      begin exec_b = ALU_B_RS2; exec_op = ALU_OP_FUNCT; end
            CL_IALU:   begin exec_b = ALU_B_IMM; exec_op = ALU_OP_FUNCT; end
            CL_LOAD,
            CL_STORE,
            CL_JALR:   exec_b = ALU_B_IMM;
            CL_BRANCH: exec_op = ALU_OP_CMP;
            CL_LUI:    begin exec_a = ALU_A_ZERO; exec_b = ALU_B_IMM; end
            CL_AUIPC:  begin exec_a = ALU_A_PC;   exec_b = ALU_B_IMM; end
            default:   ;
        endcase
    end

    // Next-state and outputs. Selects are Moore; mem_ack-qualified strobes (ir_write,
    // store completion) and branch_taken->pc_src are the only input-dependent terms.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        imm_sel_d = imm_sel_q;
        bus_err_d = bus_err_q;
        armed_d   = 1'b1;

        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_src   = 1'b0;
        ir_write  = 1'b0;
        imm_sel   = imm_sel_q;
        alu_src_a = ALU_A_RS1;
        alu_src_b = ALU_B_RS2;
        alu_op    = ALU_OP_ADD;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_PLUS4;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        retire    = 1'b0;
        trap      = 1'b0;

        case (state_q)
            // START spans one full cycle after the first edge out of reset, so the
            // first fetch request appears at the second rising edge.
            ST_START: begin
                imm_sel = '0;
                if (armed_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                mem_src = 1'b0;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    cls_d     = dec_cls;
                    imm_sel_d = dec_imm;
                    state_d   = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                end
            end
            ST_EXEC: begin
                alu_src_a = exec_a;
                alu_src_b = exec_b;
                alu_op    = exec_op;
                case (cls_q)
                    CL_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CL_LOAD,
                    CL_STORE: state_d = ST_MEM;
                    default:  state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                alu_src_a = exec_a;
                alu_src_b = exec_b;
                alu_op    = exec_op;
                mem_req   = 1'b1;
                mem_src   = 1'b1;
                mem_we    = (cls_q == CL_STORE);
                if (mem_ack) begin
                    if (cls_q == CL_STORE) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_PLUS4;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_WB: begin
                alu_src_a = exec_a;
                alu_src_b = exec_b;
                alu_op    = exec_op;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                case (cls_q)
                    CL_LOAD: wb_sel = WB_MEM;
                    CL_JAL:  begin wb_sel = WB_PC4; pc_src = PC_SRC_IMM; end
                    CL_JALR: begin wb_sel = WB_PC4; pc_src = PC_SRC_ALU; end
                    default: ;
                endcase
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                imm_sel = '0;
                trap    = 1'b1;
            end
            default: state_d = ST_TRAP;
        endcase
    end

    // Timeout counter: counts unacked request cycles, saturates, clears on ack or leaving FETCH/MEM.
    always_comb begin
        cnt_d = '0;
        if (mem_req && !mem_ack && (state_d == ST_FETCH || state_d == ST_MEM))
            cnt_d = timeout ? cnt_q : cnt_q + 1'b1;
    end

    // State and latched decode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_START;
            cls_q     <= CL_R;
            imm_sel_q <= IMM_I;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            imm_sel_q <= imm_sel_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            armed_q   <= armed_d;
        end
    end

endmodule
